// File: rtl/linecard_rx_arbiter_pkg.sv
// Shared types and constants for the line-card fabric front end.
package linecard_fabric_pkg;

   localparam int unsigned NUM_LINECARD_PORTS = 12;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   typedef logic [3:0] src_port_t;

endpackage

// File: rtl/linecard_rx_arbiter_if.sv
// Bundle of the N RX AXI-Stream ports, per-port enables and the merged TX stream.
// master: the line-card / downstream side; slave: the arbiter.
interface linecard_rx_arbiter_if
   import linecard_fabric_pkg::*;
#(
   parameter int NUM_PORTS  = NUM_LINECARD_PORTS,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int SRC_WIDTH  = $clog2(NUM_PORTS)
);

   logic [NUM_PORTS-1:0]              port_enable;
   logic [NUM_PORTS-1:0]              rx_tvalid;
   logic [NUM_PORTS-1:0]              rx_tready;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   rx_tdata;
   logic [NUM_PORTS*DATA_WIDTH/8-1:0] rx_tkeep;
   logic [NUM_PORTS*USER_WIDTH-1:0]   rx_tuser;
   logic [NUM_PORTS-1:0]              rx_tlast;

   logic                              tx_tvalid;
   logic                              tx_tready;
   logic [DATA_WIDTH-1:0]             tx_tdata;
   logic [DATA_WIDTH/8-1:0]           tx_tkeep;
   logic [USER_WIDTH-1:0]             tx_tuser;
   logic                              tx_tlast;
   logic [SRC_WIDTH-1:0]              tx_src;

   modport master (
      output port_enable, rx_tvalid, rx_tdata, rx_tkeep, rx_tuser, rx_tlast, tx_tready,
      input  rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tuser, tx_tlast, tx_src
   );

   modport slave (
      input  port_enable, rx_tvalid, rx_tdata, rx_tkeep, rx_tuser, rx_tlast, tx_tready,
      output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tuser, tx_tlast, tx_src
   );

endinterface

// File: rtl/linecard_rx_arbiter_skid.sv
// linecard_rx_skid: 2-entry AXI-Stream register slice. The output register
// drives the consumer directly; the hold register absorbs the one beat that
// arrives while the output is stalled. s_ready is purely registered.
module linecard_rx_skid #(
   parameter int BEAT_WIDTH = 8
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BEAT_WIDTH-1:0] s_beat,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [BEAT_WIDTH-1:0] m_beat
);

   logic [BEAT_WIDTH-1:0] out_q;
   logic [BEAT_WIDTH-1:0] hold_q;
   logic                  out_valid;
   logic                  hold_valid;

   assign s_ready = ~hold_valid;
   assign m_valid = out_valid;
   assign m_beat  = out_q;

   // Refill the output slot when it frees (hold first to keep order), else park in hold.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         out_q      <= '0;
         hold_q     <= '0;
         out_valid  <= 1'b0;
         hold_valid <= 1'b0;
      end else if (!out_valid || m_ready) begin
         if (hold_valid) begin
            out_q      <= hold_q;
            out_valid  <= 1'b1;
            hold_valid <= 1'b0;
         end else if (s_valid) begin
            out_q     <= s_beat;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (s_valid && !hold_valid) begin
         hold_q     <= s_beat;
         hold_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/linecard_rx_arbiter.sv
// linecard_rx_arbiter: round-robin, frame-atomic N:1 merge of line-card RX
// streams, each output beat tagged with its source port. Disabled ports are
// sunk. Optional macro LINECARD_RX_ARB_STATS_EN adds per-port frame counters
// on stats_frames.
module linecard_rx_arbiter
   import linecard_fabric_pkg::*;
#(
   parameter int NUM_PORTS  = NUM_LINECARD_PORTS,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int SRC_WIDTH  = $clog2(NUM_PORTS)
) (
   input  logic aclk,
   input  logic areset_n,
   linecard_rx_arbiter_if.slave bus
`ifdef LINECARD_RX_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*32-1:0] stats_frames
`endif
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1 + SRC_WIDTH;

   arb_state_t             state;
   logic [SRC_WIDTH-1:0]   grant_q;
   logic                   running;

   logic [NUM_PORTS-1:0]   req;
   logic [SRC_WIDTH-1:0]   pick;
   logic [NUM_PORTS-1:0]   grant_onehot;

   logic                   sel_valid;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [KEEP_WIDTH-1:0]  sel_keep;
   logic [USER_WIDTH-1:0]  sel_user;
   logic                   sel_last;

   logic                   skid_valid_in;
   logic                   skid_ready;
   logic                   beat_acc;
   logic [BEAT_WIDTH-1:0]  skid_out;

   assign req = bus.rx_tvalid & bus.port_enable;

   // Round-robin search starting just after the last grant; the nearest requester wins.
   always_comb begin
      logic [SRC_WIDTH-1:0] idx;
      pick = grant_q;
      for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
         idx = SRC_WIDTH'((32'(grant_q) + k) % NUM_PORTS);
         if (req[idx]) pick = idx;
      end
   end

   // Mux the granted port's beat and build its one-hot mask.
   always_comb begin
      sel_valid    = 1'b0;
      sel_data     = '0;
      sel_keep     = '0;
      sel_user     = '0;
      sel_last     = 1'b0;
      grant_onehot = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (grant_q == SRC_WIDTH'(p)) begin
            grant_onehot[p] = 1'b1;
            sel_valid       = bus.rx_tvalid[p];
            sel_data        = bus.rx_tdata[p*DATA_WIDTH +: DATA_WIDTH];
            sel_keep        = bus.rx_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
            sel_user        = bus.rx_tuser[p*USER_WIDTH +: USER_WIDTH];
            sel_last        = bus.rx_tlast[p];
         end
      end
   end

   assign skid_valid_in = (state == ARB_LOCKED) && sel_valid;
   assign beat_acc      = skid_valid_in && skid_ready;

   // Disabled ports sink freely unless they hold the grant; enabled ones wait for it.
   always_comb begin
      bus.rx_tready = '0;
      if (running) begin
         bus.rx_tready = ~bus.port_enable;
         if (state == ARB_LOCKED)
            bus.rx_tready = (bus.rx_tready & ~grant_onehot) |
                            (grant_onehot & {NUM_PORTS{skid_ready}});
      end
   end

   // Arbitration FSM: one IDLE cycle to pick a port, LOCKED until its tlast is accepted.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state   <= ARB_IDLE;
         grant_q <= SRC_WIDTH'(NUM_PORTS - 1);
         running <= 1'b0;
      end else begin
         running <= 1'b1;
         case (state)
            ARB_IDLE: begin
               if (running && (req != '0)) begin
                  grant_q <= pick;
                  state   <= ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               if (beat_acc && sel_last) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   linecard_rx_skid #(
      .BEAT_WIDTH (BEAT_WIDTH)
   ) u_skid (
      .aclk     (aclk),
      .areset_n (areset_n),
      .s_valid  (skid_valid_in),
      .s_ready  (skid_ready),
      .s_beat   ({sel_data, sel_keep, sel_user, sel_last, grant_q}),
      .m_valid  (bus.tx_tvalid),
      .m_ready  (bus.tx_tready),
      .m_beat   (skid_out)
   );

   assign {bus.tx_tdata, bus.tx_tkeep, bus.tx_tuser, bus.tx_tlast, bus.tx_src} = skid_out;

`ifdef LINECARD_RX_ARB_STATS_EN
   logic [31:0] frame_cnt [NUM_PORTS];

   // Count frames per port on the accepted tlast beat; wraps naturally.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) frame_cnt[p] <= '0;
      end else if (beat_acc && sel_last) begin
         frame_cnt[grant_q] <= frame_cnt[grant_q] + 32'd1;
      end
   end

   // Flatten the counters onto the stats bus.
   always_comb begin
      stats_frames = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) stats_frames[p*32 +: 32] = frame_cnt[p];
   end
`endif

endmodule

// File: tb/tb_linecard_rx_arbiter.sv
// Randomised bench for linecard_rx_arbiter against a frame-level reference model:
// round-robin grant over requesting ports, a 2-deep output FIFO, per-port sinks.
module tb_linecard_rx_arbiter;
   import linecard_fabric_pkg::*;

   localparam int NP = NUM_LINECARD_PORTS;
   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int UW = 1;
   localparam int SW = $clog2(NP);

   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   always #5 aclk = ~aclk;

   linecard_rx_arbiter_if #(
      .NUM_PORTS (NP), .DATA_WIDTH (DW), .USER_WIDTH (UW), .SRC_WIDTH (SW)
   ) bus ();

`ifdef LINECARD_RX_ARB_STATS_EN
   logic [NP*32-1:0] stats_frames;
`endif

   linecard_rx_arbiter #(
      .NUM_PORTS (NP), .DATA_WIDTH (DW), .USER_WIDTH (UW), .SRC_WIDTH (SW)
   ) dut (
      .aclk     (aclk),
      .areset_n (areset_n),
      .bus      (bus)
`ifdef LINECARD_RX_ARB_STATS_EN
      ,
      .stats_frames (stats_frames)
`endif
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
      src_port_t     src;
   } beat_t;

   beat_t       src_q [NP][$];   // beats still to be offered by each port
   beat_t       exp_q [$];       // beats accepted but not yet seen on tx
   logic [NP-1:0] present;
   logic [NP-1:0] enables;
   int          valid_pct;
   int          tready_pct;
   bit          tready_pat [$];
   int          pat_i;

   bit          m_locked;
   int          m_grant;
   int          m_ptr;
   int unsigned m_frames [NP];

   int unsigned n_vec, n_bad;
   int          cyc, first_req_cyc, first_tx_cyc;
   int          frame_srcs [$];
   int          frame_users [$];
   int          beats_out;
   bit          tx_mid;
   int          lo5;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic queue_frame(input int p, input int len, input logic [UW-1:0] user1);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = $urandom;
         b.keep = KW'($urandom_range(1, (1 << KW) - 1));
         b.user = (i == 0) ? user1 : UW'($urandom_range(0, 1));
         b.last = (i == len - 1);
         b.src  = src_port_t'(p);
         src_q[p].push_back(b);
      end
   endtask

   function automatic int pending();
      int n = exp_q.size();
      for (int p = 0; p < NP; p++) n += src_q[p].size();
      return n;
   endfunction

   task automatic clear_log();
      frame_srcs.delete();
      frame_users.delete();
      beats_out = 0;
      first_req_cyc = -1;
      first_tx_cyc = -1;
      lo5 = 0;
   endtask

   // One clock: drive at the falling edge, compare, then advance the model.
   task automatic cycle();
      logic [NP-1:0] req, exp_rdy, rx_fire;
      bit was_locked;
      beat_t b;
      @(negedge aclk);
      cyc++;
      bus.port_enable = enables;
      for (int p = 0; p < NP; p++) begin
         if (!present[p] && src_q[p].size() > 0 && $urandom_range(0, 99) < valid_pct)
            present[p] = 1'b1;
         bus.rx_tvalid[p] = present[p];
         if (present[p]) begin
            b = src_q[p][0];
            bus.rx_tdata[p*DW +: DW] = b.data;
            bus.rx_tkeep[p*KW +: KW] = b.keep;
            bus.rx_tuser[p*UW +: UW] = b.user;
            bus.rx_tlast[p]          = b.last;
         end else begin
            bus.rx_tdata[p*DW +: DW] = $urandom;
            bus.rx_tkeep[p*KW +: KW] = '0;
            bus.rx_tuser[p*UW +: UW] = '0;
            bus.rx_tlast[p]          = 1'($urandom_range(0, 1));
         end
      end
      if (tready_pat.size() > 0) begin
         bus.tx_tready = tready_pat[pat_i % tready_pat.size()];
         pat_i++;
      end else begin
         bus.tx_tready = ($urandom_range(0, 99) < tready_pct);
      end
      #1;
      req     = bus.rx_tvalid & bus.port_enable;
      exp_rdy = ~bus.port_enable;
      if (m_locked) exp_rdy[m_grant] = (exp_q.size() < 2);
      check_eq("rx_tready", 64'(bus.rx_tready), 64'(exp_rdy));
      check_eq("tx_tvalid", 64'(bus.tx_tvalid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         b = exp_q[0];
         check_eq("tx_tdata", 64'(bus.tx_tdata), 64'(b.data));
         check_eq("tx_tkeep", 64'(bus.tx_tkeep), 64'(b.keep));
         check_eq("tx_tuser", 64'(bus.tx_tuser), 64'(b.user));
         check_eq("tx_tlast", 64'(bus.tx_tlast), 64'(b.last));
         check_eq("tx_src",   64'(bus.tx_src),   64'(b.src));
      end
      if (first_req_cyc < 0 && bus.rx_tvalid != '0) first_req_cyc = cyc;
      if (first_tx_cyc < 0 && bus.tx_tvalid) first_tx_cyc = cyc;
      if (bus.rx_tvalid[5] && !bus.rx_tready[5] && m_locked && m_grant == 5) lo5++;

      if (exp_q.size() > 0 && bus.tx_tready) begin
         b = exp_q.pop_front();
         if (!tx_mid) begin
            frame_srcs.push_back(int'(b.src));
            frame_users.push_back(int'(b.user));
         end
         tx_mid = !b.last;
         beats_out++;
      end
      rx_fire    = bus.rx_tvalid & exp_rdy;
      was_locked = m_locked;
      for (int p = 0; p < NP; p++) begin
         if (rx_fire[p]) begin
            b = src_q[p].pop_front();
            present[p] = 1'b0;
            if (was_locked && p == m_grant) begin
               exp_q.push_back(b);
               if (b.last) begin
                  m_locked = 1'b0;
                  m_frames[p]++;
               end
            end
         end
      end
      if (!was_locked && req != '0) begin
         for (int k = NP; k >= 1; k--)
            if (req[(m_ptr + k) % NP]) m_grant = (m_ptr + k) % NP;
         m_ptr    = m_grant;
         m_locked = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge aclk);
      areset_n = 1'b0;
      #1;
      check_eq("rst_rx_tready", 64'(bus.rx_tready), 64'(0));
      check_eq("rst_tx_tvalid", 64'(bus.tx_tvalid), 64'(0));
      check_eq("rst_tx_tdata",  64'(bus.tx_tdata),  64'(0));
      check_eq("rst_tx_src",    64'(bus.tx_src),    64'(0));
      check_eq("rst_tx_tlast",  64'(bus.tx_tlast),  64'(0));
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         m_frames[p] = 0;
      end
      exp_q.delete();
      present        = '0;
      bus.rx_tvalid  = '0;
      bus.rx_tlast   = '0;
      m_locked = 1'b0;
      m_ptr    = NP - 1;
      m_grant  = 0;
      tx_mid   = 1'b0;
      repeat (3) @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk);
`ifdef LINECARD_RX_ARB_STATS_EN
      #1;
      for (int p = 0; p < NP; p++)
         check_eq("stats_after_reset", 64'(stats_frames[p*32 +: 32]), 64'(0));
`endif
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (pending() > 0 && n < budget) begin
         cycle();
         n++;
      end
      check_eq("drain_pending", 64'(pending()), 64'(0));
      repeat (3) cycle();
   endtask

   initial begin
      n_vec = 0; n_bad = 0; cyc = 0; pat_i = 0;
      valid_pct = 100; tready_pct = 100;
      enables = '1;
      present = '0;
      bus.port_enable = '1;
      bus.rx_tvalid = '0; bus.rx_tdata = '0; bus.rx_tkeep = '0;
      bus.rx_tuser = '0;  bus.rx_tlast = '0; bus.tx_tready = 1'b0;
      do_reset();

      // Single 4-beat frame from port 0: 2-cycle latency.
      clear_log();
      queue_frame(0, 4, 1'b0);
      drain(50);
      check_eq("first_latency", 64'(first_tx_cyc - first_req_cyc), 64'(2));
      check_eq("p0_beats", 64'(beats_out), 64'(4));
      check_eq("p0_src", 64'(frame_srcs.size() > 0 ? frame_srcs[0] : -1), 64'(0));

      // Ports 0, 3, 11 each with two 2-beat frames: strict rotation.
      do_reset();
      clear_log();
      for (int r = 0; r < 2; r++) begin
         queue_frame(0, 2, 1'b0);
         queue_frame(3, 2, 1'b0);
         queue_frame(11, 2, 1'b0);
      end
      drain(100);
      begin
         int ord [6] = '{0, 3, 11, 0, 3, 11};
         check_eq("rr_count", 64'(frame_srcs.size()), 64'(6));
         for (int i = 0; i < 6 && i < frame_srcs.size(); i++)
            check_eq("rr_order", 64'(frame_srcs[i]), 64'(ord[i]));
      end

      // 8-beat frame from port 5 under 1,0,0,1 back-pressure.
      clear_log();
      tready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      pat_i = 0;
      queue_frame(5, 8, 1'b0);
      drain(100);
      tready_pat.delete();
      check_eq("p5_beats", 64'(beats_out), 64'(8));
      check_eq("p5_stalled", 64'(lo5 > 0), 64'(1));

      // Disabled port 2 is sunk; port 4 disabled mid-frame still completes.
      clear_log();
      enables[2] = 1'b0;
      for (int i = 0; i < 3; i++) queue_frame(2, 3, 1'b0);
      drain(60);
      check_eq("p2_dropped", 64'(beats_out), 64'(0));
      queue_frame(4, 8, 1'b0);
      repeat (3) cycle();
      enables[4] = 1'b0;
      drain(60);
      check_eq("p4_beats", 64'(beats_out), 64'(8));
      check_eq("p4_frames", 64'(frame_srcs.size()), 64'(1));
      enables = '1;

      // Port 7 back-to-back single-beat frames, tuser 0 then 1.
      clear_log();
      queue_frame(7, 1, 1'b0);
      queue_frame(7, 1, 1'b1);
      drain(40);
      check_eq("p7_frames", 64'(frame_srcs.size()), 64'(2));
      if (frame_users.size() == 2) begin
         check_eq("p7_user0", 64'(frame_users[0]), 64'(0));
         check_eq("p7_user1", 64'(frame_users[1]), 64'(1));
      end

      // Reset in the middle of a port-1 frame, then ports 0 and 1 contend.
      queue_frame(1, 8, 1'b0);
      repeat (4) cycle();
      do_reset();
      clear_log();
      queue_frame(1, 2, 1'b0);
      queue_frame(0, 2, 1'b0);
      drain(60);
      check_eq("post_rst_first", 64'(frame_srcs.size() > 0 ? frame_srcs[0] : -1), 64'(0));

      // Random traffic, random enables and back-pressure.
      clear_log();
      valid_pct = 80; tready_pct = 70;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 99) < 30) begin
            int p = $urandom_range(0, NP - 1);
            if (src_q[p].size() < 16)
               queue_frame(p, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 99) < 3) enables[$urandom_range(0, NP - 1)] ^= 1'b1;
         cycle();
      end
      valid_pct = 100; tready_pct = 100;
      drain(2000);
`ifdef LINECARD_RX_ARB_STATS_EN
      #1;
      for (int p = 0; p < NP; p++)
         check_eq("stats_frames", 64'(stats_frames[p*32 +: 32]), 64'(m_frames[p]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/linecard_rx_arbiter.md
Name: linecard_rx_arbiter

Overview:
Round-robin, frame-atomic N:1 merge of the line-card RX AXI-Stream ports produced by the SMPM quad. It replaces the always-ready dummy sink and is the first stage of the switch fabric. Each output frame is tagged with its source port index. Output is registered through a 2-entry skid buffer, so full throughput is sustained within a frame.

Parameters:
NUM_PORTS, 12, number of RX line-card ports merged
DATA_WIDTH, 32, tdata width in bits (multiple of 8)
USER_WIDTH, 1, tuser width; bit 0 = frame error flag, passed through untouched
SRC_WIDTH, $clog2(NUM_PORTS), width of source-port tag

Ports:
aclk  in  1  fabric clock; all RX and TX signals are synchronous to it
areset_n  in  1  asynchronous active-low reset
port_enable  in  NUM_PORTS  per-port enable; a disabled port is sunk (discarded)
rx_tvalid  in  NUM_PORTS  per-port valid
rx_tready  out  NUM_PORTS  per-port ready
rx_tdata  in  NUM_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH]
rx_tkeep  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables
rx_tuser  in  NUM_PORTS*USER_WIDTH  per-port user/error bits
rx_tlast  in  NUM_PORTS  per-port end of frame
tx_tvalid  out  1  merged stream valid
tx_tready  in  1  merged stream ready
tx_tdata  out  DATA_WIDTH  merged data
tx_tkeep  out  DATA_WIDTH/8  merged byte enables
tx_tuser  out  USER_WIDTH  merged user bits
tx_tlast  out  1  merged end of frame
tx_src  out  SRC_WIDTH  source port of the current beat; constant across a frame

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; rx_tready all 0
  - FSM = IDLE
  - last-grant pointer = NUM_PORTS-1, so port 0 has first priority
  - skid buffer empty
- FSM IDLE:
  - req = rx_tvalid & port_enable
  - If req != 0, grant the first set bit searching ptr+1, ptr+2 … wrapping modulo NUM_PORTS. Register grant, set ptr = grant, go to LOCKED.
  - rx_tready is 0 for enabled ports while IDLE.
- FSM LOCKED:
  - rx_tready[grant] = skid buffer can accept.
  - A beat is transferred when rx_tvalid[grant] && rx_tready[grant]; it is pushed with tx_src = grant.
  - An accepted beat with tlast returns the FSM to IDLE.
  - All other enabled ports have rx_tready = 0.
- Disabled ports:
  - rx_tready = 1 at all times unless currently granted; beats are dropped.
  - port_enable is sampled only at grant time. Deasserting it mid-frame does not abort: the frame completes normally.
- Latency and throughput:
  - First beat appears on tx 2 cycles after rx_tvalid in IDLE (1 cycle arbitration, 1 cycle skid register).
  - 1-beat/cycle within a frame.
  - Exactly 1 bubble cycle between consecutive frames (the IDLE arbitration cycle).
- Single-beat frame (tlast on the first beat): accepted, then IDLE on the next cycle.
- Skid buffer:
  - tx_tvalid is registered and never combinationally dependent on tx_tready.
  - Back-pressure: the buffer holds 2 beats and rx_tready[grant] falls the cycle after it fills. No beat is ever lost or duplicated.
- Source tagging: tx_tdata, tx_tkeep, tx_tuser, tx_tlast and tx_src change only on a tx handshake or when the buffer is empty.
- Fairness: a port with rx_tvalid held waits at most NUM_PORTS-1 frames.
- Reset mid-frame: everything clears immediately and the partial frame is truncated with no tlast. Downstream must drop on its own reset.

Optional Feature:
LINECARD_RX_ARB_STATS_EN
- Defined: adds output stats_frames (NUM_PORTS*32) holding a per-port 32-bit count of frames forwarded.
  - A count increments on an accepted tlast beat from that port.
  - Counts wrap at 2^32-1 → 0 and reset to 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package linecard_fabric_pkg:
  - NUM_LINECARD_PORTS = 12
  - typedef arb_state_t enum {ARB_IDLE, ARB_LOCKED}
  - typedef src_port_t logic[3:0]
- Sub-module linecard_rx_skid: 2-entry AXI-Stream register slice carrying data, keep, user, last and src.

Test Plan:
- Port 0 sends a 4-beat frame with tx_tready=1 → tx carries 4 beats with tx_src=0, first beat 2 cycles after rx_tvalid, tlast on beat 4.
- Ports 0, 3 and 11 all hold rx_tvalid with 2-beat frames, repeating → frames emitted in order 0,3,11,0,3,11 with 1 bubble between frames.
- tx_tready toggles 1,0,0,1 during an 8-beat frame from port 5 → all 8 beats out in order, none duplicated, rx_tready[5] low while the buffer is full.
- port_enable[2]=0 while port 2 sends 3 frames → rx_tready[2]=1, nothing on tx. Then deassert port_enable[4] mid-frame → port 4's frame completes intact.
- Port 7 sends single-beat frames back-to-back with tuser=1 on the second → two 1-beat tx frames with tlast=1, tuser passed as 0 then 1, tx_src=7.
- Assert areset_n=0 mid-frame from port 1 → tx_tvalid=0 and rx_tready=0 the same cycle. After release, port 0 wins when ports 0 and 1 both request. With LINECARD_RX_ARB_STATS_EN, counts read 0 after reset.
